// File: rtl/data_memory.sv
// data_memory: word-organised data memory for the MEM stage of the single-cycle CPU.
// Synchronous write on rising clock_in, combinational read gated by memRead.
// Asynchronous active-low reset_n clears every word.
// Optional build macro: DMEM_RANGE_CHECK_EN
//   defined   - any set address bit above ADDR_WIDTH drops the write and forces readData to 0
//   undefined - upper address bits are ignored, addresses alias modulo the depth
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  memWrite,
    input  logic                  memRead,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;

    assign idx = address[ADDR_WIDTH-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    // Word indices beyond the array are rejected rather than wrapped.
    assign in_range = (address[31:ADDR_WIDTH] == '0);
`else
    // Upper bits deliberately ignored so addresses alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_WIDTH];
    assign in_range       = 1'b1;
`endif

    // Storage: cleared asynchronously, written on the rising edge when enabled.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memWrite && in_range) begin
            mem[idx] <= writeData;
        end
    end

    // Combinational read; no write bypass, so a same-cycle write shows only after the edge.
    always_comb begin
        readData = '0;
        if (memRead && in_range) begin
            readData = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by randomized
// read/write traffic, all compared against an array-based reference model.
module tb_data_memory;

    logic        clock_in;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;

    logic [31:0] ref_mem [64];
    int          n_checks;
    int          n_pass;

    data_memory dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .address   (address),
        .writeData (writeData),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .readData  (readData)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    function automatic bit addr_ok(input logic [31:0] a);
        return !(RANGE_CHECK && (a >= 32'd64));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
        if (!rd || !addr_ok(a)) return 32'h0;
        return ref_mem[a % 64];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (addr_ok(a)) ref_mem[a % 64] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic rd);
        address = a;
        memRead = rd;
        #1;
        check(tag, readData, model_read(a, rd));
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock_in);
        address   = a;
        writeData = d;
        memWrite  = 1'b1;
        @(posedge clock_in);
        model_write(a, d);
        @(negedge clock_in);
        memWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        wr;
        logic        rd;

        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b1;
        address   = 32'h0;
        writeData = 32'h0;
        memWrite  = 1'b0;
        memRead   = 1'b1;
        model_clear();

        // Reset: readData zero at arbitrary addresses while held
        #2 reset_n = 1'b0;
        read_check("reset_hold_a0", 32'd0, 1'b1);
        read_check("reset_hold_a15", 32'd15, 1'b1);
        read_check("reset_hold_a63", 32'd63, 1'b1);
        @(negedge clock_in);
        reset_n = 1'b1;
        for (int i = 0; i < 64; i++) read_check("post_reset_sweep", i, 1'b1);

        // Basic write then read-back
        write_word(32'd15, 32'hFFFF_0000);
        read_check("wr_rd_15", 32'd15, 1'b1);
        check("wr_rd_15_const", readData, 32'hFFFF_0000);

        // Read gating without any clock involvement
        read_check("gate_off_15", 32'd15, 1'b0);
        check("gate_off_const", readData, 32'h0);
        read_check("gate_on_15", 32'd15, 1'b1);

        // Simultaneous read and write: old word before the edge, new word after
        write_word(32'd3, 32'h1234_5678);
        @(negedge clock_in);
        address   = 32'd3;
        memRead   = 1'b1;
        writeData = 32'hCAFE_BABE;
        memWrite  = 1'b1;
        #1 check("rw_before_edge", readData, 32'h1234_5678);
        @(posedge clock_in);
        model_write(32'd3, 32'hCAFE_BABE);
        #1 check("rw_after_edge", readData, 32'hCAFE_BABE);
        @(negedge clock_in);
        memWrite = 1'b0;

        // Out-of-range address 79: aliases to word 15, or is rejected with the range check
        write_word(32'd79, 32'hA5A5_A5A5);
        read_check("alias_rd_15", 32'd15, 1'b1);
        read_check("alias_rd_79", 32'd79, 1'b1);
        check("alias_15_const", (RANGE_CHECK ? 32'hFFFF_0000 : 32'hA5A5_A5A5) ^ readData,
              RANGE_CHECK ? 32'hFFFF_0000 : 32'h0);

        // Randomized traffic, each cycle checked before and after the edge
        for (int n = 0; n < 300; n++) begin
            @(negedge clock_in);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
            d  = $urandom;
            wr = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) != 0);
            address   = a;
            writeData = d;
            memWrite  = wr;
            memRead   = rd;
            #1 check("rand_pre_edge", readData, model_read(a, rd));
            @(posedge clock_in);
            if (wr) model_write(a, d);
            #1 check("rand_post_edge", readData, model_read(a, rd));
        end
        @(negedge clock_in);
        memWrite = 1'b0;

        // Reset pulse mid-cycle with a write pending: clears at once, write is lost
        write_word(32'd20, 32'hDEAD_BEEF);
        read_check("pre_pulse_20", 32'd20, 1'b1);
        @(negedge clock_in);
        #2;
        address   = 32'd20;
        memRead   = 1'b1;
        writeData = 32'h7777_7777;
        memWrite  = 1'b1;
        reset_n   = 1'b0;
        model_clear();
        #1 check("pulse_immediate_20", readData, 32'h0);
        read_check("pulse_immediate_15", 32'd15, 1'b1);
        @(posedge clock_in);
        #1 check("pulse_write_ignored", readData, 32'h0);
        @(negedge clock_in);
        memWrite = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 64; i++) read_check("post_pulse_sweep", i, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
